// File: rtl/fifo_drain_streamer.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional STREAM_STATS_EN macro enables the delivered-word counter on words_out.
module fifo_drain_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  err_underflow,
  output logic [31:0]           words_out
);

  generate
    if (SKID_DEPTH != 2) begin : g_bad_skid_depth
      $error("fifo_drain_streamer: SKID_DEPTH must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic                  err_q, err_d;

  logic       pop;
  logic       push;
  logic [1:0] occ_cnt;
  logic [2:0] slots_used;

  assign occ_cnt    = occ_q;
  assign slots_used = {1'b0, occ_cnt} + {2'b00, inflight_q};
  assign m_valid    = (occ_q != OCC_EMPTY);
  assign m_data     = head_q;
  assign pop        = m_valid & m_ready;
  assign push       = inflight_q & ~fifo_underflow;

  // A pop this cycle frees a slot in time for the word returning next cycle.
  assign fifo_rd_en = en & ~fifo_empty & ((slots_used < 3'd2) | pop);

  assign err_underflow = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_rd_en;
    err_d      = err_q | (inflight_q & fifo_underflow);

    case ({push, pop})
      2'b10: begin
        case (occ_q)
          OCC_EMPTY: begin
            head_d = fifo_data_out;
            occ_d  = OCC_ONE;
          end
          OCC_ONE: begin
            tail_d = fifo_data_out;
            occ_d  = OCC_TWO;
          end
          default: occ_d = occ_q;
        endcase
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      end
      2'b11: begin
        // Head is leaving: with one entry the new word becomes the head directly.
        if (occ_q == OCC_ONE) begin
          head_d = fifo_data_out;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data_out;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

`ifdef STREAM_STATS_EN
  logic [31:0] words_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
    end else if (pop) begin
      words_q <= words_q + 32'd1;
    end
  end

  assign words_out = words_q;
`else
  assign words_out = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_streamer.sv
// Directed bench for fifo_drain_streamer: a queue-based FIFO model feeds the DUT and a
// scoreboard checks order, throughput, backpressure, en drop, underflow and reset.
module tb_fifo_drain_streamer;
  localparam int W = 16;

`ifdef STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         fifo_empty;
  logic [W-1:0] fifo_data_out;
  logic         fifo_underflow;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         err_underflow;
  logic [31:0]  words_out;

  always #5 clk = ~clk;

  fifo_drain_streamer #(.FIFO_WIDTH(W), .SKID_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .err_underflow  (err_underflow),
    .words_out      (words_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ret_data;
  logic         ret_valid;
  logic         ret_uf;
  logic         prev_stall;
  logic [W-1:0] prev_d;
  logic         last_rd;
  logic         last_valid;
  int           cnt;
  int           rd_total;
  int           pop_total;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample just after, update model.
  task automatic step();
    logic         rd;
    logic         v;
    logic         pop;
    logic         discard;
    logic [W-1:0] d;
    logic [W-1:0] w;
    logic [W-1:0] e;
    fifo_empty     = (fq.size() == 0);
    fifo_data_out  = ret_data;
    fifo_underflow = ret_valid & ret_uf;
    #1;
    rd  = fifo_rd_en;
    v   = m_valid;
    d   = m_data;
    pop = v & m_ready;
    check_eq("rd_while_empty", {31'b0, rd & fifo_empty}, 32'd0);
    check_eq("occ_bound", {31'b0, (cnt <= 2)}, 32'd1);
    if (prev_stall) begin
      check_eq("valid_hold", {31'b0, v}, 32'd1);
      check_eq("data_hold", {16'b0, d}, {16'b0, prev_d});
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_unexpected", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("order", {16'b0, d}, {16'b0, e});
        $display("pop word 0x%04h", d);
      end
    end
    discard = ret_valid & ret_uf;
    cnt     = cnt + int'(rd) - int'(pop) - int'(discard);
    ret_valid = 1'b0;
    ret_uf    = 1'b0;
    if (rd && fq.size() > 0) begin
      w         = fq.pop_front();
      ret_data  = w;
      ret_valid = 1'b1;
      ret_uf    = (w == 16'hDEAD);
      if (!ret_uf) exp_q.push_back(w);
    end
    rd_total  += int'(rd);
    pop_total += int'(pop);
    prev_stall = v & ~m_ready;
    prev_d     = d;
    if (rst) begin
      exp_q.delete();
      cnt        = 0;
      ret_valid  = 1'b0;
      ret_uf     = 1'b0;
      prev_stall = 1'b0;
    end
    last_rd    = rd;
    last_valid = v;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((fq.size() != 0 || cnt != 0) && k < 60) begin
      step();
      k++;
    end
    check_eq({tag, "_drain_in_time"}, {31'b0, (k < 60)}, 32'd1);
  endtask

  initial begin
    logic [11:0] rd_bits;
    logic [11:0] v_bits;
    int r0;
    int p0;

    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    fifo_data_out = '0; fifo_underflow = 1'b0;
    ret_data = '0; ret_valid = 1'b0; ret_uf = 1'b0;
    prev_stall = 1'b0; prev_d = '0; cnt = 0; rd_total = 0; pop_total = 0;
    last_rd = 1'b0; last_valid = 1'b0;

    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_eq("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    check_eq("rst_m_data", {16'b0, m_data}, 32'd0);
    check_eq("rst_err", {31'b0, err_underflow}, 32'd0);
    check_eq("rst_words", words_out, 32'd0);

    // Latency/throughput: reads on cycles 0..7; m_valid rises on the edge after the
    // one that samples the first rd_en, i.e. cycles 2..9 at the falling-edge sample.
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    en = 1'b1; m_ready = 1'b1;
    rd_bits = '0; v_bits = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      rd_bits[c] = last_rd;
      v_bits[c]  = last_valid;
    end
    check_eq("lat_rd_pattern", {20'b0, rd_bits}, 32'h0FF);
    check_eq("lat_valid_pattern", {20'b0, v_bits}, 32'h3FC);
    check_eq("lat_pops", pop_total, 32'd8);
    check_eq("lat_words_out", words_out, STATS ? 32'd8 : 32'd0);

    // Backpressure: only two reads fit, head held at 0xA000.
    for (int i = 0; i < 6; i++) fq.push_back(16'hA000 + 16'(i));
    m_ready = 1'b0;
    r0 = rd_total;
    repeat (10) step();
    check_eq("bp_reads", rd_total - r0, 32'd2);
    check_eq("bp_occ", cnt, 32'd2);
    check_eq("bp_valid", {31'b0, m_valid}, 32'd1);
    check_eq("bp_head", {16'b0, m_data}, 32'hA000);
    m_ready = 1'b1;
    p0 = pop_total;
    drain("bp");
    check_eq("bp_delivered", pop_total - p0, 32'd6);

    // Empty-boundary toggling: one word, then a gap cycle.
    p0 = pop_total;
    for (int i = 0; i < 6; i++) begin
      fq.push_back(16'h5000 + 16'(i));
      step();
      step();
    end
    drain("gap");
    check_eq("gap_delivered", pop_total - p0, 32'd6);
    check_eq("gap_err", {31'b0, err_underflow}, 32'd0);

    // en drop with occ=1 and one word in flight.
    for (int i = 0; i < 4; i++) fq.push_back(16'hB000 + 16'(i));
    step();
    step();
    check_eq("endrop_pre_occ", cnt, 32'd2);
    en = 1'b0;
    r0 = rd_total;
    p0 = pop_total;
    repeat (6) step();
    check_eq("endrop_reads", rd_total - r0, 32'd0);
    check_eq("endrop_delivered", pop_total - p0, 32'd2);
    check_eq("endrop_fifo_left", fq.size(), 32'd2);
    en = 1'b1;
    drain("endrop");

    // Forced underflow on the return carrying 0xDEAD.
    fq.push_back(16'hC000);
    fq.push_back(16'hDEAD);
    fq.push_back(16'hC001);
    p0 = pop_total;
    drain("uf");
    check_eq("uf_delivered", pop_total - p0, 32'd2);
    check_eq("uf_err_set", {31'b0, err_underflow}, 32'd1);
    repeat (5) step();
    check_eq("uf_err_sticky", {31'b0, err_underflow}, 32'd1);

    // Reset with occ=2: buffered words vanish, error and counter clear.
    for (int i = 0; i < 4; i++) fq.push_back(16'hD000 + 16'(i));
    m_ready = 1'b0;
    repeat (4) step();
    check_eq("rstmid_occ", cnt, 32'd2);
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check_eq("rstmid_valid", {31'b0, m_valid}, 32'd0);
    check_eq("rstmid_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    check_eq("rstmid_err", {31'b0, err_underflow}, 32'd0);
    check_eq("rstmid_words", words_out, 32'd0);
    en = 1'b1;
    m_ready = 1'b1;
    p0 = pop_total;
    drain("rstmid");
    check_eq("rstmid_delivered", pop_total - p0, 32'd2);
    check_eq("rstmid_words_after", words_out, STATS ? 32'd2 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
